// File: rtl/recv_pkg.sv
// Shared types and constants for the delayed-pulse link receiver.
// Optional build macro used by the receiver: RECV_GLITCH_FILTER_EN.
package recv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEASURE  = 2'd1,
        WAIT_LOW = 2'd2,
        HOLDOFF  = 2'd3
    } state_e;

    localparam logic [1:0] ERR_SHORT = 2'b01;
    localparam logic [1:0] ERR_LONG  = 2'b10;
    localparam logic [1:0] ERR_EARLY = 2'b11;

    localparam int WIDTH_W = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Line synchroniser with rise/fall detection for the pulse receiver.
// With RECV_GLITCH_FILTER_EN defined, a registered 3-sample majority filter sits after s2.
module sync_edge_det
    import recv_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic s_level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic level_s;

    // Two-flop synchroniser plus history flop on the filtered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
            s3_q <= level_s;
        end
    end

`ifdef RECV_GLITCH_FILTER_EN
    logic h1_q;
    logic h2_q;
    logic filt_q;

    // Majority of three consecutive samples; a lone high or low sample never wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_q   <= 1'b0;
            h2_q   <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            h1_q   <= s2_q;
            h2_q   <= h1_q;
            filt_q <= maj3(s2_q, h1_q, h2_q);
        end
    end

    assign level_s = filt_q;
`else
    assign level_s = s2_q;
`endif

    assign s_level_o = level_s;
    assign rise_o    = level_s & ~s3_q;
    assign fall_o    = ~level_s & s3_q;

endmodule

// File: rtl/recv_and_unpack_signal.sv
// Receive end of the single-wire delayed-pulse link: width check, holdoff, count, timeout.
// Optional build macro: RECV_GLITCH_FILTER_EN (majority filter inside sync_edge_det).
module recv_and_unpack_signal
    import recv_pkg::*;
#(
    parameter int MIN_WIDTH   = 3,
    parameter int MAX_WIDTH   = 6,
    parameter int HOLDOFF_CYC = 290_000,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               signal,
    output logic               pulse_valid,
    output logic               pulse_err,
    output logic [1:0]         err_code,
    output logic [WIDTH_W-1:0] width_last,
    output logic [15:0]        pulse_cnt,
    output logic               timeout
);

    // MAX_WIDTH must stay below 255 so the saturation value fits the width counter.
    localparam logic [WIDTH_W-1:0] MIN_W   = WIDTH_W'(MIN_WIDTH);
    localparam logic [WIDTH_W-1:0] MAX_W   = WIDTH_W'(MAX_WIDTH);
    localparam logic [WIDTH_W-1:0] SAT_W   = WIDTH_W'(MAX_WIDTH + 1);
    localparam logic [CNT_W-1:0]   HO_LAST = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [CNT_W-1:0]   TO_LIM  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

    logic s_level_s;
    logic rise_s;
    logic fall_s;

    state_e             state_q, state_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [CNT_W-1:0]   hcnt_q, hcnt_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d;
    logic               timeout_q, timeout_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;
    logic [WIDTH_W-1:0] wl_q, wl_d;
    logic [15:0]        pulse_cnt_q, pulse_cnt_d;

    sync_edge_det u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_i     (signal),
        .s_level_o (s_level_s),
        .rise_o    (rise_s),
        .fall_o    (fall_s)
    );

    // Next-state, counter and strobe logic.
    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        code_d      = code_q;
        wl_d        = wl_q;
        pulse_cnt_d = pulse_cnt_q;

        if (rise_s) begin
            width_d = 8'd1;
        end else if (s_level_s && (width_q != SAT_W)) begin
            width_d = width_q + 8'd1;
        end else begin
            width_d = width_q;
        end

        tcnt_d    = (tcnt_q == CNT_MAX) ? tcnt_q : tcnt_q + CNT_W'(1);
        timeout_d = timeout_q | ((TIMEOUT_CYC != 0) && (tcnt_d >= TO_LIM));

        case (state_q)
            IDLE: begin
                if (rise_s) begin
                    state_d = MEASURE;
                end else begin
                    state_d = IDLE;
                end
            end
            MEASURE: begin
                if (fall_s) begin
                    if (width_q > MAX_W) begin
                        // Fall lands exactly on the saturation cycle: still too long.
                        err_d   = 1'b1;
                        code_d  = ERR_LONG;
                        state_d = IDLE;
                    end else if (width_q >= MIN_W) begin
                        valid_d     = 1'b1;
                        wl_d        = width_q;
                        pulse_cnt_d = (pulse_cnt_q == 16'hFFFF) ? pulse_cnt_q
                                                                : pulse_cnt_q + 16'd1;
                        tcnt_d      = {CNT_W{1'b0}};
                        timeout_d   = 1'b0;
                        hcnt_d      = {CNT_W{1'b0}};
                        state_d     = HOLDOFF;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_SHORT;
                        wl_d    = width_q;
                        state_d = IDLE;
                    end
                end else if (s_level_s && (width_q == SAT_W)) begin
                    err_d   = 1'b1;
                    code_d  = ERR_LONG;
                    state_d = WAIT_LOW;
                end else begin
                    state_d = MEASURE;
                end
            end
            WAIT_LOW: begin
                if (!s_level_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_LOW;
                end
            end
            HOLDOFF: begin
                hcnt_d = hcnt_q + CNT_W'(1);
                // Skip the flag right after the accept strobe so strobes never abut.
                if (rise_s && !valid_q) begin
                    err_d  = 1'b1;
                    code_d = ERR_EARLY;
                end else begin
                    err_d  = 1'b0;
                end
                if (hcnt_q == HO_LAST) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLDOFF;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            width_q     <= 8'd0;
            hcnt_q      <= {CNT_W{1'b0}};
            tcnt_q      <= {CNT_W{1'b0}};
            timeout_q   <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= 2'b00;
            wl_q        <= 8'd0;
            pulse_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            hcnt_q      <= hcnt_d;
            tcnt_q      <= tcnt_d;
            timeout_q   <= timeout_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            code_q      <= code_d;
            wl_q        <= wl_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign pulse_valid = valid_q;
    assign pulse_err   = err_q;
    assign err_code    = code_q;
    assign width_last  = wl_q;
    assign pulse_cnt   = pulse_cnt_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_recv_and_unpack_signal.sv
// Self-checking bench for recv_and_unpack_signal against a pulse-classification model.
// Honours RECV_GLITCH_FILTER_EN for the single-cycle glitch expectation.
module tb_recv_and_unpack_signal;

    localparam int MINW = 3;
    localparam int MAXW = 6;
    localparam int HO   = 20;
    localparam int TO   = 100;
`ifdef RECV_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig = 1'b0;
    logic        pulse_valid;
    logic        pulse_err;
    logic [1:0]  err_code;
    logic [7:0]  width_last;
    logic [15:0] pulse_cnt;
    logic        timeout;

    always #5 clk = ~clk;

    recv_and_unpack_signal #(
        .MIN_WIDTH   (MINW),
        .MAX_WIDTH   (MAXW),
        .HOLDOFF_CYC (HO),
        .TIMEOUT_CYC (TO),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .signal      (sig),
        .pulse_valid (pulse_valid),
        .pulse_err   (pulse_err),
        .err_code    (err_code),
        .width_last  (width_last),
        .pulse_cnt   (pulse_cnt),
        .timeout     (timeout)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int n_v, n_e, consec, both;
    logic [1:0] code_seen;
    logic       to_at_v;
    logic       prev_s;

    // Reference model state: counts, last width/code, last accepted pulse rise and width.
    int m_cnt, m_wl, m_code, acc_rise, acc_w, base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (pulse_valid) begin
            n_v++;
            to_at_v = timeout;
        end
        if (pulse_err) begin
            n_e++;
            code_seen = err_code;
        end
        if (pulse_valid && pulse_err) both++;
        if ((pulse_valid || pulse_err) && prev_s) consec++;
        prev_s = pulse_valid || pulse_err;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_wl = 0; m_code = 0;
        acc_rise = -1000; acc_w = 0;
    endtask

    task automatic chk_to(input string tag);
        int d;
        d = cyc - base;
        if (d > TO + 12) chk(tag, {31'd0, timeout}, 32'd1);
        else if (d < TO - 2) chk(tag, {31'd0, timeout}, 32'd0);
    endtask

    // Drive one pulse of w cycles, idle gap cycles, then compare with the model.
    task automatic send(input int w, input int gap, input string tag);
        int t;
        bit ev, ee;
        int ec;
        t = cyc; ev = 1'b0; ee = 1'b0; ec = m_code;
        if (t - acc_rise < acc_w + HO + 1) begin
            ee = 1'b1; ec = 3;
        end else if (w > MAXW) begin
            ee = 1'b1; ec = 2;
        end else if (w >= MINW) begin
            ev = 1'b1;
            m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
            m_wl = w; acc_rise = t; acc_w = w; base = t;
        end else if (FILT && w == 1) begin
            ee = 1'b0;
        end else begin
            ee = 1'b1; ec = 1; m_wl = w;
        end
        m_code = ec;
        n_v = 0; n_e = 0; to_at_v = 1'bx; code_seen = 2'bxx;
        sig = 1'b1;
        repeat (w) tick();
        sig = 1'b0;
        repeat (gap) tick();
        chk({tag, "_valid_cnt"}, n_v, {31'd0, ev});
        chk({tag, "_err_cnt"}, n_e, {31'd0, ee});
        if (ee) chk({tag, "_code_strobe"}, {30'd0, code_seen}, ec);
        if (ev) chk({tag, "_timeout_at_valid"}, {31'd0, to_at_v}, 32'd0);
        chk({tag, "_pulse_cnt"}, {16'd0, pulse_cnt}, m_cnt);
        chk({tag, "_width_last"}, {24'd0, width_last}, m_wl);
        chk({tag, "_err_code_hold"}, {30'd0, err_code}, m_code);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, pulse_valid}, 32'd0);
        chk({tag, "_err"}, {31'd0, pulse_err}, 32'd0);
        chk({tag, "_code"}, {30'd0, err_code}, 32'd0);
        chk({tag, "_wl"}, {24'd0, width_last}, 32'd0);
        chk({tag, "_cnt"}, {16'd0, pulse_cnt}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    endtask

    initial begin
        consec = 0; both = 0; prev_s = 1'b0;
        model_reset();
        rst_n = 1'b0; sig = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        base = cyc;
        repeat (5) tick();
        chk_zero("reset");
        chk_to("timeout_after_reset");

        send(4, 40, "clean");
        chk_to("timeout_after_clean");
        send(2, 30, "short");
        repeat (5) tick();
        chk("short_code_holds", {30'd0, err_code}, m_code);
        send(10, 30, "long");
        chk_to("timeout_idle");
        send(4, 6, "after_long");
        send(4, 16, "early");
        send(4, 30, "spaced");
        send(1, 30, "glitch");
        send(3 + $urandom_range(0, 3), 40, "rand_ok");
        send(($urandom_range(0, 1) == 0) ? 7 : 8, 40, "rand_long");

        // Reset cut in the middle of a pulse; the line stays high through release.
        sig = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        repeat (2) tick();
        model_reset();
        rst_n = 1'b1;
        base = cyc;
        n_v = 0; n_e = 0;
        m_cnt = 1; m_wl = 4; acc_rise = cyc; acc_w = 4;
        repeat (4) tick();
        sig = 1'b0;
        repeat (20) tick();
        chk("cut_valid_cnt", n_v, 32'd1);
        chk("cut_err_cnt", n_e, 32'd0);
        chk("cut_width_last", {24'd0, width_last}, m_wl);
        chk("cut_pulse_cnt", {16'd0, pulse_cnt}, m_cnt);

        repeat (10) tick();
        force dut.pulse_cnt_q = 16'hFFFF;
        tick();
        release dut.pulse_cnt_q;
        m_cnt = 65535;
        chk("forced_cnt", {16'd0, pulse_cnt}, m_cnt);
        send(4, 30, "saturate");

        chk("strobes_consecutive", consec, 32'd0);
        chk("strobes_both", both, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
